// File: rtl/qspi_slave_xcvr_if.sv
// qspi_slave_xcvr_if
// Bundles the SPI pin-side signals (QCK, QSS, QD_IN, QD_OUT) and the
// byte-plus-strobe user side (rxdata/rxready, txdata/txready) of the
// multi-lane SPI slave transceiver.
//   slave  modport : seen by the transceiver itself
//   master modport : seen by whatever drives the SPI pins and consumes bytes
interface qspi_slave_xcvr_if #(
    parameter int DWIDTH = 2
);
    logic              QCK;
    logic              QSS;
    logic [DWIDTH-1:0] QD_IN;
    logic [DWIDTH-1:0] QD_OUT;
    logic [7:0]        rxdata;
    logic              rxready;
    logic [7:0]        txdata;
    logic              txready;

    modport slave (
        input  QCK, QSS, QD_IN, txdata,
        output QD_OUT, rxdata, rxready, txready
    );

    modport master (
        output QCK, QSS, QD_IN, txdata,
        input  QD_OUT, rxdata, rxready, txready
    );
endinterface

// File: rtl/qspi_slave_xcvr.sv
// qspi_slave_xcvr
// Single/dual/quad SPI mode-0 slave transceiver. All SPI pins are
// synchronised into CLK; a byte is 8/DWIDTH QCK cycles, MSB-first, with
// lane DWIDTH-1 carrying the more significant bit of each group.
// Ports:
//   CLK  : system clock, all outputs registered on its rising edge
//   RST  : asynchronous active-low reset
//   bus  : qspi_slave_xcvr_if.slave (QCK, QSS, QD_IN, QD_OUT,
//          rxdata, rxready, txdata, txready)
module qspi_slave_xcvr #(
    parameter int DWIDTH = 2
) (
    input  logic               CLK,
    input  logic               RST,
    qspi_slave_xcvr_if.slave   bus
);
    localparam int         BEATS     = 8 / DWIDTH;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    // synchroniser chains and registered edge detects
    logic              qck_meta_r, qck_sync_r, qck_prev_r;
    logic              qss_meta_r, ss_sync_r, ss_prev_r;
    logic [DWIDTH-1:0] qd_meta_r, qd_sync_r;
    logic              rise_r, fall_r, sel_r;
    logic              ss_s;

    // receive path
    logic [2:0]        rx_cnt_r, rx_cnt_n;
    logic [7:0]        rx_shift_r, rx_shift_n, rx_assembled_s;
    logic [7:0]        rxdata_r, rxdata_n;
    logic              rxready_r, rxready_n;

    // transmit path
    logic [2:0]        tx_cnt_r, tx_cnt_n;
    logic [7:0]        tx_shift_r, tx_shift_n, tx_shifted_s;
    logic [DWIDTH-1:0] qd_out_r, qd_out_n;
    logic              txready_r, txready_n;

    assign ss_s = ss_sync_r;

    // Two-flop synchronisers plus a third QCK/QSS copy; edge pulses are
    // registered so every action sees them with the same fixed latency.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            qck_meta_r <= 1'b0;
            qck_sync_r <= 1'b0;
            qck_prev_r <= 1'b0;
            qss_meta_r <= 1'b1;
            ss_sync_r  <= 1'b1;
            ss_prev_r  <= 1'b1;
            qd_meta_r  <= {DWIDTH{1'b0}};
            qd_sync_r  <= {DWIDTH{1'b0}};
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            sel_r      <= 1'b0;
        end else begin
            qck_meta_r <= bus.QCK;
            qck_sync_r <= qck_meta_r;
            qck_prev_r <= qck_sync_r;
            qss_meta_r <= bus.QSS;
            ss_sync_r  <= qss_meta_r;
            ss_prev_r  <= ss_sync_r;
            qd_meta_r  <= bus.QD_IN;
            qd_sync_r  <= qd_meta_r;
            rise_r     <= qck_sync_r & ~qck_prev_r;
            fall_r     <= ~qck_sync_r & qck_prev_r;
            sel_r      <= ss_prev_r & ~ss_sync_r;
        end
    end

    // Receive next-state: shift lanes in on QCK rise, publish on the last beat.
    always_comb begin
        rx_cnt_n       = rx_cnt_r;
        rx_shift_n     = rx_shift_r;
        rxdata_n       = rxdata_r;
        rxready_n      = 1'b0;
        rx_assembled_s = {rx_shift_r[7-DWIDTH:0], qd_sync_r};
        if (ss_s) begin
            // deselected: any partial byte is dropped
            rx_cnt_n   = 3'd0;
            rx_shift_n = 8'h00;
        end else if (rise_r) begin
            if (rx_cnt_r == LAST_BEAT) begin
                rx_cnt_n   = 3'd0;
                rx_shift_n = 8'h00;
                rxdata_n   = rx_assembled_s;
                rxready_n  = 1'b1;
            end else begin
                rx_cnt_n   = rx_cnt_r + 3'd1;
                rx_shift_n = rx_assembled_s;
            end
        end else begin
            rx_cnt_n   = rx_cnt_r;
            rx_shift_n = rx_shift_r;
        end
    end

    // Transmit next-state: load on select, shift on QCK fall, reload at the
    // byte boundary so consecutive bytes follow without a gap.
    always_comb begin
        tx_cnt_n     = tx_cnt_r;
        tx_shift_n   = tx_shift_r;
        qd_out_n     = qd_out_r;
        txready_n    = 1'b0;
        tx_shifted_s = {tx_shift_r[7-DWIDTH:0], {DWIDTH{1'b0}}};
        if (ss_s) begin
            tx_cnt_n = 3'd0;
            qd_out_n = {DWIDTH{1'b0}};
        end else if (sel_r) begin
            tx_cnt_n   = 3'd0;
            tx_shift_n = bus.txdata;
            qd_out_n   = bus.txdata[7 -: DWIDTH];
            txready_n  = 1'b1;
        end else if (fall_r) begin
            if (tx_cnt_r == LAST_BEAT) begin
                tx_cnt_n   = 3'd0;
                tx_shift_n = bus.txdata;
                qd_out_n   = bus.txdata[7 -: DWIDTH];
                txready_n  = 1'b1;
            end else begin
                tx_cnt_n   = tx_cnt_r + 3'd1;
                tx_shift_n = tx_shifted_s;
                qd_out_n   = tx_shifted_s[7 -: DWIDTH];
            end
        end else begin
            tx_cnt_n   = tx_cnt_r;
            tx_shift_n = tx_shift_r;
        end
    end

    // Receive and transmit state registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_cnt_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rxdata_r   <= 8'h00;
            rxready_r  <= 1'b0;
            tx_cnt_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            qd_out_r   <= {DWIDTH{1'b0}};
            txready_r  <= 1'b0;
        end else begin
            rx_cnt_r   <= rx_cnt_n;
            rx_shift_r <= rx_shift_n;
            rxdata_r   <= rxdata_n;
            rxready_r  <= rxready_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_shift_r <= tx_shift_n;
            qd_out_r   <= qd_out_n;
            txready_r  <= txready_n;
        end
    end

    assign bus.QD_OUT  = qd_out_r;
    assign bus.rxdata  = rxdata_r;
    assign bus.rxready = rxready_r;
    assign bus.txready = txready_r;
endmodule

// File: tb/tb_qspi_slave_xcvr.sv
// Self-checking bench: one transceiver per lane width (1, 2, 4), driven one
// at a time by a behavioural SPI master. Expected rx bytes are the bytes the
// master sends; expected tx bytes are the sequence of txdata values the bench
// presents (initial value, then a new one after each txready).
module tb_qspi_slave_xcvr;
    localparam int HIGH_HALF = 6;
    localparam int SETUP     = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] qck_v, qss_v;
    logic [3:0] qd_in_v   [3];
    logic [7:0] txd_v     [3];
    logic [3:0] qd_out_v  [3];
    logic [7:0] rxdata_v  [3];
    logic [2:0] rxready_v, txready_v;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         act      = 0;
    int         tx_idx   = 0;
    int         tx_pulses = 0;
    int         low_half = 5;
    int         dws [3] = '{1, 2, 4};
    logic [7:0] rx_q [$];
    logic [7:0] mosi_b  [16];
    logic [7:0] tx_plan [16];

    always #5 clk = ~clk;

    qspi_slave_xcvr_if #(.DWIDTH(1)) if0 ();
    qspi_slave_xcvr_if #(.DWIDTH(2)) if1 ();
    qspi_slave_xcvr_if #(.DWIDTH(4)) if2 ();

    assign if0.QCK = qck_v[0];  assign if0.QSS = qss_v[0];
    assign if1.QCK = qck_v[1];  assign if1.QSS = qss_v[1];
    assign if2.QCK = qck_v[2];  assign if2.QSS = qss_v[2];
    assign if0.QD_IN = qd_in_v[0][0:0];
    assign if1.QD_IN = qd_in_v[1][1:0];
    assign if2.QD_IN = qd_in_v[2];
    assign if0.txdata = txd_v[0];
    assign if1.txdata = txd_v[1];
    assign if2.txdata = txd_v[2];
    assign qd_out_v[0] = {3'b000, if0.QD_OUT};
    assign qd_out_v[1] = {2'b00, if1.QD_OUT};
    assign qd_out_v[2] = if2.QD_OUT;
    assign rxdata_v[0] = if0.rxdata;
    assign rxdata_v[1] = if1.rxdata;
    assign rxdata_v[2] = if2.rxdata;
    assign rxready_v = {if2.rxready, if1.rxready, if0.rxready};
    assign txready_v = {if2.txready, if1.txready, if0.txready};

    qspi_slave_xcvr #(.DWIDTH(1)) dut0 (.CLK(clk), .RST(rst_n), .bus(if0.slave));
    qspi_slave_xcvr #(.DWIDTH(2)) dut1 (.CLK(clk), .RST(rst_n), .bus(if1.slave));
    qspi_slave_xcvr #(.DWIDTH(4)) dut2 (.CLK(clk), .RST(rst_n), .bus(if2.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // strobe monitor: collects rx bytes, feeds the tx plan, checks pulse width
    initial begin
        logic [2:0] rx_prev;
        logic [2:0] tx_prev;
        rx_prev = 3'b000;
        tx_prev = 3'b000;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rxready_v[k]) begin
                    chk("rx_single_pulse", 32'(rx_prev[k]), 32'd0);
                    if (k == act) rx_q.push_back(rxdata_v[k]);
                end
                if (txready_v[k]) begin
                    chk("tx_single_pulse", 32'(tx_prev[k]), 32'd0);
                    if (k == act) begin
                        tx_pulses++;
                        tx_idx++;
                        if (tx_idx < 16) txd_v[k] = tx_plan[tx_idx];
                    end
                end
            end
            rx_prev = rxready_v;
            tx_prev = txready_v;
        end
    end

    // one QCK cycle: present lanes during low phase, sample QD_OUT at rise
    task automatic do_beat(input int w, input logic [3:0] lanes, input bit byte_end,
                           output logic [3:0] sampled);
        qd_in_v[w] = lanes;
        repeat (low_half) @(negedge clk);
        sampled  = qd_out_v[w];
        qck_v[w] = 1'b1;
        for (int i = 1; i <= HIGH_HALF; i++) begin
            @(negedge clk);
            if (byte_end && i <= 5) chk("rx_latency", 32'(rxready_v[w]), 32'(i == 4));
        end
        qck_v[w] = 1'b0;
    endtask

    task automatic send_byte(input int w, input logic [7:0] mosi, input int nbeats,
                             output logic [7:0] miso);
        int         dw;
        int         beats;
        int         mask;
        logic [3:0] s;
        dw    = dws[w];
        beats = 8 / dw;
        mask  = (1 << dw) - 1;
        miso  = 8'h00;
        for (int k = 0; k < nbeats; k++) begin
            do_beat(w, 4'((int'(mosi) >> (8 - dw * (k + 1))) & mask), (k == beats - 1), s);
            miso = 8'((int'(miso) << dw) | (int'(s) & mask));
        end
    endtask

    task automatic start_sel(input int w);
        rx_q.delete();
        tx_pulses = 0;
        tx_idx    = 0;
        act       = w;
        txd_v[w]  = tx_plan[0];
        qss_v[w]  = 1'b0;
        repeat (SETUP) @(negedge clk);
    endtask

    task automatic run_xfer(input int w, input int n);
        logic [7:0] miso;
        start_sel(w);
        for (int b = 0; b < n; b++) begin
            send_byte(w, mosi_b[b], 8 / dws[w], miso);
            chk("tx_byte", 32'(miso), 32'(tx_plan[b]));
        end
        repeat (6) @(negedge clk);
        qss_v[w] = 1'b1;
        repeat (8) @(negedge clk);
        chk("rx_count", 32'(rx_q.size()), 32'(n));
        for (int b = 0; b < n; b++) begin
            if (b < rx_q.size()) chk("rx_byte", 32'(rx_q[b]), 32'(mosi_b[b]));
        end
        chk("tx_pulses", 32'(tx_pulses), 32'(n + 1));
        chk("qd_out_idle", 32'(qd_out_v[w]), 32'd0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < 16; i++) begin
            tx_plan[i] = 8'($urandom);
            if (i < n) mosi_b[i] = 8'($urandom);
        end
    endtask

    initial begin
        logic [7:0] miso;
        int         w;
        int         n;
        rst_n = 1'b0;
        qck_v = 3'b000;
        qss_v = 3'b111;
        for (int k = 0; k < 3; k++) begin
            qd_in_v[k] = 4'h0;
            txd_v[k]   = 8'h00;
        end
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_rxdata", 32'(rxdata_v[k]), 32'd0);
            chk("reset_qd_out", 32'(qd_out_v[k]), 32'd0);
            chk("reset_rxready", 32'(rxready_v[k]), 32'd0);
            chk("reset_txready", 32'(txready_v[k]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // dual lane, single byte 0xA5
        fill_random(1);
        mosi_b[0] = 8'hA5;
        run_xfer(1, 1);

        // single and quad lane, 0x3C then 0xC3 back-to-back
        for (int k = 0; k < 3; k += 2) begin
            fill_random(2);
            mosi_b[0] = 8'h3C;
            mosi_b[1] = 8'hC3;
            low_half  = 4 + k;
            run_xfer(k, 2);
        end

        // tx sequence 0x96 then 0x5A
        fill_random(2);
        tx_plan[0] = 8'h96;
        tx_plan[1] = 8'h5A;
        low_half   = 5;
        run_xfer(1, 2);

        // deselect after 2 of 4 dual-lane beats, then fresh byte 0x11
        fill_random(1);
        start_sel(1);
        send_byte(1, 8'hE7, 2, miso);
        repeat (2) @(negedge clk);
        qss_v[1] = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_rx", 32'(rx_q.size()), 32'd0);
        chk("abort_tx_pulses", 32'(tx_pulses), 32'd1);
        fill_random(1);
        mosi_b[0] = 8'h11;
        run_xfer(1, 1);
        chk("abort_rxdata", 32'(rxdata_v[1]), 32'h11);

        // reset mid-byte
        fill_random(1);
        tx_plan[0] = 8'hFF;
        start_sel(1);
        send_byte(1, 8'h5A, 2, miso);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rxdata", 32'(rxdata_v[1]), 32'd0);
        chk("rst_qd_out", 32'(qd_out_v[1]), 32'd0);
        chk("rst_rxready", 32'(rxready_v[1]), 32'd0);
        chk("rst_txready", 32'(txready_v[1]), 32'd0);
        qss_v[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_no_rx", 32'(rx_q.size()), 32'd0);
        fill_random(1);
        run_xfer(1, 1);

        // full duplex 0xF0 in, 0x0F out on every width
        for (int k = 0; k < 3; k++) begin
            fill_random(1);
            mosi_b[0]  = 8'hF0;
            tx_plan[0] = 8'h0F;
            run_xfer(k, 1);
        end

        // random transfers
        for (int r = 0; r < 6; r++) begin
            w        = int'($urandom_range(0, 2));
            n        = int'($urandom_range(1, 4));
            low_half = int'($urandom_range(4, 7));
            fill_random(n);
            run_xfer(w, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
